// File: rtl/fib_control.sv
// Sequencing FSM for an iterative Fibonacci datapath: loads F(0)/F(1), steps the
// shift/sum registers N-1 times and reports the index reached plus adder overflow.
module fib_control #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] n_in,
  input  logic              overflow,
  output logic              enable_reg1,
  output logic              enable_reg2,
  output logic              enable_regN,
  output logic              enable_count,
  output logic              sel_init,
  output logic              res_sel,
  output logic [DATA_W-1:0] iter,
  output logic              busy,
  output logic              done,
  output logic              err_ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] n_q;
  logic [DATA_W-1:0] iter_inc;
  logic [DATA_W:0]   iter_ext;
  logic              last_step;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + DATA_W'(1);
  endfunction

  assign iter_inc  = sat_inc(iter);
  // One extra bit so iter + 1 cannot wrap onto a small n_q.
  assign iter_ext  = {1'b0, iter} + (DATA_W + 1)'(1);
  assign last_step = (iter_ext == {1'b0, n_q});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (abort)                     state_nxt = IDLE;
        else if (n_q <= DATA_W'(1))    state_nxt = DONE;
        else                           state_nxt = STEP;
      end
      STEP: begin
        if (abort)                     state_nxt = IDLE;
        else if (overflow || last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_q     <= '0;
      iter    <= '0;
      err_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_q     <= n_in;
          err_ovf <= 1'b0;
        end
        LOAD: if (!abort) begin
          iter    <= DATA_W'(1);
          err_ovf <= 1'b0;
        end
        // Abort beats overflow: the step is discarded and the flag left alone.
        STEP: if (!abort) begin
          iter <= iter_inc;
          if (overflow) err_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    enable_reg1  = 1'b0;
    enable_reg2  = 1'b0;
    enable_regN  = 1'b0;
    enable_count = 1'b0;
    sel_init     = 1'b0;
    res_sel      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      LOAD: begin
        sel_init    = 1'b1;
        enable_reg1 = 1'b1;
        enable_reg2 = 1'b1;
        enable_regN = 1'b1;
        busy        = 1'b1;
      end
      STEP: begin
        enable_reg1  = 1'b1;
        enable_reg2  = 1'b1;
        enable_count = 1'b1;
        busy         = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        res_sel = (n_q == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fib_control.md
FIB_CONTROL -- requirements
Module: fib_control

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: start  in  1  request a new computation; sampled only in IDLE.
REQ-004 SHALL have ports: abort  in  1  cancel a running computation.
REQ-005 SHALL have ports: n_in  in  8  requested Fibonacci index N; latched on accepted start.
REQ-006 SHALL have ports: overflow  in  1  datapath adder carry-out for the current step.
REQ-007 SHALL have ports: enable_reg1, enable_reg2, enable_regN, enable_count  out  1 each  datapath register enables.
REQ-008 SHALL have ports: sel_init  out  1  1 = datapath loads initial values (reg1=0, reg2=1); 0 = shift/sum.
REQ-009 SHALL have ports: res_sel  out  1  1 = result taken from reg1; 0 = result taken from reg2.
REQ-010 SHALL have ports: iter  out  8  current index k held in reg2 (reg2 = F(k)).
REQ-011 SHALL have ports: busy, done, err_ovf  out  1 each  status.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, LOAD, STEP and DONE; all outputs except iter/err_ovf SHALL be decoded from state only.
REQ-013 IDLE: all enables = 0, busy = 0; start = 1 SHALL latch n_in into n_q and SHALL move to LOAD.
REQ-014 LOAD (1 cycle): sel_init = 1, enable_reg1 = enable_reg2 = enable_regN = 1, busy = 1, iter <= 1, err_ovf <= 0.
REQ-015 LOAD SHALL go to DONE if n_q <= 1 and to STEP otherwise.
REQ-016 STEP: sel_init = 0, enable_reg1 = enable_reg2 = enable_count = 1, enable_regN = 0, busy = 1, iter <= iter + 1 each cycle.
REQ-017 STEP SHALL go to DONE on the cycle where iter + 1 == n_q, giving exactly n_q - 1 STEP cycles.
REQ-018 overflow = 1 in any STEP cycle SHALL set err_ovf = 1 and SHALL go to DONE next, with iter still incremented for that step.
REQ-019 DONE (1 cycle): done = 1, busy = 0, all enables = 0; res_sel = 1 if n_q == 0, else 0; next state IDLE.
REQ-020 Latency from the start-sampling edge: done SHALL be high in cycle 2 for N <= 1 and in cycle N + 1 for N >= 2 (LOAD = cycle 1).
REQ-021 start SHALL be ignored outside IDLE; n_q SHALL remain stable from LOAD through DONE.
REQ-022 abort = 1 in LOAD or STEP SHALL force IDLE on the next edge with no done pulse and err_ovf unchanged; abort SHALL be ignored in IDLE and DONE.
REQ-023 If abort and overflow are both high in the same STEP cycle, abort SHALL win (IDLE, err_ovf not set).
REQ-024 iter SHALL saturate at 255 and never wrap; err_ovf SHALL hold until the next accepted start.
REQ-025 The iteration counter and n_q SHALL be 8-bit unsigned; comparisons SHALL be unsigned.

Reset
REQ-026 reset = 0 SHALL immediately force IDLE, all enables = 0, sel_init = 0, res_sel = 0, busy = 0, done = 0, err_ovf = 0, iter = 0 and n_q = 0, independent of clock.
REQ-027 Reset asserted mid-STEP SHALL abandon the computation with no done pulse; after release the first accepted start SHALL behave as from power-up.

Verification
REQ-028 N=5, start pulse: LOAD, 4 STEP cycles, done in cycle 6, iter = 5, res_sel = 0, err_ovf = 0, enable_count high exactly 4 cycles.
REQ-029 N=0 then N=1: no STEP cycles, done in cycle 2 each time; res_sel = 1 for N=0 and res_sel = 0 for N=1; iter = 1 in both.
REQ-030 N=20 with overflow driven high in the 3rd STEP cycle: DONE next cycle, err_ovf = 1, iter = 4; err_ovf clears on the next start.
REQ-031 N=10, start re-pulsed in STEP: run unaffected, done in cycle 11; then abort in 2nd STEP of a new run: IDLE next cycle, no done.
REQ-032 reset = 0 asynchronously mid-STEP (between clock edges): outputs clear at once without a clock edge; after release, N=3 completes with done in cycle 4.
